cook_time_entry: RTL and testbench
==================================

// Module: cook_time_entry
// PURPOSE
//  Keypad time-entry front end for the microwave timer: writer side of the load_minutes/load_seconds interface.
//  Accepts BCD digit presses microwave-style (1,3,0 -> 1:30), plus clear and +30 s quick-add.
//  Normalises the result to a legal M:SS value, clamped to MAX_MIN:59.
//  Drives the down counter's load inputs; locks out entry while the oven is running.
// PARAMETERS
//  MAX_MIN  59  saturation value for minutes (must be <= 63)
//  ADD_SEC  30  seconds added per add_sec press (1..59)
// PORTS
//  clk           in   1  system clock; all logic on rising edge
//  rst           in   1  synchronous, active-high reset
//  digit_valid   in   1  one-cycle strobe: digit is a new key press
//  digit         in   4  BCD key value, legal 0..9
//  clear         in   1  one-cycle strobe: discard entry
//  add_sec       in   1  one-cycle strobe: add ADD_SEC seconds
//  running       in   1  high while the counter is decrementing
//  timer_end     in   1  counter reached 0:00 (from down counter)
//  load_minutes  out  6  normalised minutes, 0..MAX_MIN
//  load_seconds  out  6  normalised seconds, 0..59
//  entry_valid   out  1  value nonzero and state != LOCKED
//  num_digits    out  3  digits held in buffer, 0..4
//  key_err       out  1  one-cycle pulse on a rejected key
// BEHAVIOUR
//  Reset: state EMPTY, buffer d3..d0 = 0, load_minutes = load_seconds = 0, entry_valid = 0, num_digits = 0, key_err = 0.
//  Buffer: accepted digit shifts in at d0; d0->d1->d2->d3. Raw min = d3*10+d2; raw sec = d1*10+d0.
//  Normalise: use 7-bit intermediates. If sec > 59: sec -= 60, min += 1.
//   If min > MAX_MIN, or min == MAX_MIN with carry overflow, saturate to MAX_MIN:59.
//  Latency: all outputs are registered; a value update is visible on the cycle after the accepting edge.
//  States:
//   EMPTY : nothing entered. Digit -> ENTRY. add_sec -> PRESET with 0:ADD_SEC.
//   ENTRY : digits accumulating. Digit with num_digits < 4 -> shift in.
//           Digit with num_digits == 4 -> key_err, no change.
//           add_sec -> PRESET; adds ADD_SEC to current outputs with carry and saturation; buffer cleared.
//   PRESET: value came from add_sec. add_sec adds again, same rules.
//           Digit -> buffer cleared, digit shifted in, value recomputed from buffer, go to ENTRY.
//   LOCKED: entered from any state when running = 1. Digit and add_sec -> key_err; outputs held; clear ignored.
//           running falls with timer_end = 0 (pause) -> ENTRY if num_digits != 0, else PRESET; value kept.
//  Digit > 9 in any state: key_err, no change.
//  Priority, highest first: rst > timer_end > running (lock) > clear > add_sec > digit_valid.
//   timer_end in any state: clear buffer and outputs, go to EMPTY.
//   clear outside LOCKED: same effect as timer_end.
//   add_sec and digit_valid in the same cycle: digit is dropped silently (no key_err).
//  Leading zeros are counted: 0,0,0,5 gives num_digits = 4 and 0:05.
//  num_digits saturates at 4.
//  key_err is high for exactly one cycle per rejected strobe; otherwise 0.
//  entry_valid = (load_minutes | load_seconds) != 0 && state != LOCKED, registered with the outputs.
//  Reset mid-entry or mid-lock returns to EMPTY on the next edge, regardless of other inputs.
// TESTING
//  Keys 1,3,0 -> after the last key plus 1 cycle: 1:30, num_digits = 3, entry_valid = 1.
//  Keys 9,9 -> 1:39 (99 s normalised). Keys 9,9,9,9 -> saturates to 59:59.
//  From EMPTY: add_sec -> 0:30; add_sec -> 1:00; then key 5 -> 0:05 in ENTRY.
//  Keys 1,2,3,4,5 -> 5th key gives a key_err pulse; value stays 12:34.
//  Key 4 -> 0:04; running = 1 -> key 7 gives key_err, 0:04 held, entry_valid = 0;
//   then timer_end -> 0:00, EMPTY.
//  clear and digit_valid in the same cycle -> 0:00, EMPTY, no key_err.
//  digit = 4'hC -> key_err, no change.

Source files
------------

// File: rtl/cook_time_entry_if.sv
// cook_time_entry_if: keypad strobes in, normalised M:SS load values and status out
interface cook_time_entry_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       clear;
  logic       add_sec;
  logic       running;
  logic       timer_end;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic       entry_valid;
  logic [2:0] num_digits;
  logic       key_err;
  modport master (
    output digit_valid, digit, clear, add_sec, running, timer_end,
    input  load_minutes, load_seconds, entry_valid, num_digits, key_err
  );
  modport slave (
    input  digit_valid, digit, clear, add_sec, running, timer_end,
    output load_minutes, load_seconds, entry_valid, num_digits, key_err
  );
endinterface

// File: rtl/cook_time_entry.sv
// cook_time_entry: microwave keypad time entry producing clamped M:SS load values for the down counter
module cook_time_entry #(
  parameter int MAX_MIN = 59,
  parameter int ADD_SEC = 30
) (
  input logic clk,
  input logic rst,
  cook_time_entry_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ENTRY, PRESET, LOCKED} state_t;
  localparam logic [6:0] MAX7 = 7'(MAX_MIN);
  localparam logic [6:0] ADD7 = 7'(ADD_SEC);
  state_t r_state, w_state;
  logic [15:0] r_buf, w_buf, w_kbuf;
  logic [5:0] r_min, r_sec, w_min, w_sec;
  logic [2:0] r_nd, w_nd;
  logic r_valid, r_err, w_err;
  logic [11:0] w_key, w_add;
  function automatic logic [11:0] norm(input logic [6:0] m, input logic [6:0] s);
    logic c;
    logic [6:0] mc;
    logic [5:0] sc;
    c = s > 7'd59;
    mc = m + {6'd0, c};
    sc = 6'(c ? s - 7'd60 : s);
    return mc > MAX7 ? {MAX7[5:0], 6'd59} : {6'(mc), sc};
  endfunction
  always_comb begin
    w_kbuf = r_state == ENTRY ? {r_buf[11:0], bus.digit} : {12'd0, bus.digit};
    w_key = norm({3'd0, w_kbuf[15:12]} * 7'd10 + {3'd0, w_kbuf[11:8]},
                 {3'd0, w_kbuf[7:4]} * 7'd10 + {3'd0, w_kbuf[3:0]});
    w_add = norm({1'b0, r_min}, {1'b0, r_sec} + ADD7);
    w_state = r_state;
    w_buf = r_buf;
    w_nd = r_nd;
    w_min = r_min;
    w_sec = r_sec;
    w_err = 1'b0;
    if (bus.timer_end) begin
      w_state = EMPTY;
      w_buf = '0;
      w_nd = '0;
      w_min = '0;
      w_sec = '0;
    end else if (bus.running || r_state == LOCKED) begin
      w_state = bus.running ? LOCKED : (r_nd != 3'd0 ? ENTRY : PRESET);
      w_err = bus.digit_valid | bus.add_sec;
    end else if (bus.clear) begin
      w_state = EMPTY;
      w_buf = '0;
      w_nd = '0;
      w_min = '0;
      w_sec = '0;
    end else if (bus.add_sec) begin
      w_state = PRESET;
      w_buf = '0;
      w_nd = '0;
      {w_min, w_sec} = w_add;
    end else if (bus.digit_valid) begin
      if (bus.digit > 4'd9 || (r_state == ENTRY && r_nd == 3'd4)) begin
        w_err = 1'b1;
      end else begin
        w_state = ENTRY;
        w_buf = w_kbuf;
        w_nd = r_state == ENTRY ? r_nd + 3'd1 : 3'd1;
        {w_min, w_sec} = w_key;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_buf <= '0;
      r_nd <= '0;
      r_min <= '0;
      r_sec <= '0;
      r_valid <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_buf <= w_buf;
      r_nd <= w_nd;
      r_min <= w_min;
      r_sec <= w_sec;
      r_valid <= (w_min | w_sec) != 6'd0 && w_state != LOCKED;
      r_err <= w_err;
    end
  end
  assign bus.load_minutes = r_min;
  assign bus.load_seconds = r_sec;
  assign bus.entry_valid = r_valid;
  assign bus.num_digits = r_nd;
  assign bus.key_err = r_err;
endmodule

// File: tb/tb_cook_time_entry.sv
// tb_cook_time_entry: directed and random keypad sequences checked against a seconds-based reference model
module tb_cook_time_entry;
  localparam int MAX_MIN = 59;
  localparam int ADD_SEC = 30;
  localparam int LIMIT = MAX_MIN * 60 + 59;
  localparam int IDLE = 0, TYPING = 1, QUICK = 2, HELD = 3;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  cook_time_entry_if bus();
  cook_time_entry #(.MAX_MIN(MAX_MIN), .ADD_SEC(ADD_SEC)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int q[$];
  int mm = 0, ss = 0, mode = IDLE;
  bit eerr = 0;
  bit run = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic set_time(input int t);
    t = t > LIMIT ? LIMIT : t;
    mm = t / 60;
    ss = t % 60;
  endtask
  task automatic wipe();
    q.delete();
    mm = 0;
    ss = 0;
    mode = IDLE;
  endtask
  task automatic model(input bit r, input bit dv, input int d, input bit clr, input bit add, input bit rn, input bit te);
    int v;
    eerr = 0;
    if (r) wipe();
    else if (te) wipe();
    else if (rn || mode == HELD) begin
      eerr = dv | add;
      mode = rn ? HELD : (q.size() != 0 ? TYPING : QUICK);
    end else if (clr) wipe();
    else if (add) begin
      set_time(mm * 60 + ss + ADD_SEC);
      q.delete();
      mode = QUICK;
    end else if (dv) begin
      if (d > 9 || (mode == TYPING && q.size() == 4)) eerr = 1;
      else begin
        if (mode != TYPING) q.delete();
        q.push_back(d);
        v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        set_time((v / 100) * 60 + v % 100);
        mode = TYPING;
      end
    end
  endtask
  task automatic cyc(input bit dv, input int d, input bit clr, input bit add, input bit rn, input bit te);
    bus.digit_valid = dv;
    bus.digit = 4'(d);
    bus.clear = clr;
    bus.add_sec = add;
    bus.running = rn;
    bus.timer_end = te;
    @(posedge clk);
    model(rst, dv, d, clr, add, rn, te);
    #1;
    check("min", bus.load_minutes, mm);
    check("sec", bus.load_seconds, ss);
    check("valid", bus.entry_valid, (mm != 0 || ss != 0) && mode != HELD);
    check("nd", bus.num_digits, q.size());
    check("err", bus.key_err, eerr);
    bus.digit_valid = 0;
    bus.clear = 0;
    bus.add_sec = 0;
    bus.timer_end = 0;
  endtask
  task automatic key(input int d);
    cyc(1, d, 0, 0, 0, 0);
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask
  task automatic clr();
    cyc(0, 0, 1, 0, 0, 0);
  endtask
  initial begin
    bus.digit_valid = 0;
    bus.digit = 0;
    bus.clear = 0;
    bus.add_sec = 0;
    bus.running = 0;
    bus.timer_end = 0;
    idle();
    idle();
    check("rst_min", bus.load_minutes, 0);
    check("rst_nd", bus.num_digits, 0);
    rst = 0;
    key(1); key(3); key(0);
    check("k130_min", bus.load_minutes, 1);
    check("k130_sec", bus.load_seconds, 30);
    check("k130_nd", bus.num_digits, 3);
    check("k130_valid", bus.entry_valid, 1);
    clr();
    key(9); key(9);
    check("k99_min", bus.load_minutes, 1);
    check("k99_sec", bus.load_seconds, 39);
    clr();
    key(9); key(9); key(9); key(9);
    check("k9999_min", bus.load_minutes, 59);
    check("k9999_sec", bus.load_seconds, 59);
    clr();
    cyc(0, 0, 0, 1, 0, 0);
    check("add1_sec", bus.load_seconds, 30);
    cyc(0, 0, 0, 1, 0, 0);
    check("add2_min", bus.load_minutes, 1);
    check("add2_sec", bus.load_seconds, 0);
    key(5);
    check("add_key_min", bus.load_minutes, 0);
    check("add_key_sec", bus.load_seconds, 5);
    check("add_key_nd", bus.num_digits, 1);
    clr();
    key(1); key(2); key(3); key(4); key(5);
    check("k5_err", bus.key_err, 1);
    check("k5_min", bus.load_minutes, 12);
    check("k5_sec", bus.load_seconds, 34);
    idle();
    check("k5_err_pulse", bus.key_err, 0);
    clr();
    key(0); key(0); key(0); key(5);
    check("lz_nd", bus.num_digits, 4);
    check("lz_sec", bus.load_seconds, 5);
    clr();
    key(4);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 7, 0, 0, 1, 0);
    check("lock_err", bus.key_err, 1);
    check("lock_sec", bus.load_seconds, 4);
    check("lock_valid", bus.entry_valid, 0);
    cyc(0, 0, 1, 0, 1, 0);
    check("lock_clear_ign", bus.load_seconds, 4);
    cyc(0, 0, 0, 0, 0, 1);
    check("tend_sec", bus.load_seconds, 0);
    check("tend_valid", bus.entry_valid, 0);
    key(3);
    cyc(1, 8, 1, 0, 0, 0);
    check("clr_dig_sec", bus.load_seconds, 0);
    check("clr_dig_err", bus.key_err, 0);
    key(2);
    key(12);
    check("hexc_err", bus.key_err, 1);
    check("hexc_sec", bus.load_seconds, 2);
    clr();
    key(4);
    cyc(0, 0, 0, 0, 1, 0);
    idle();
    key(5);
    check("pause_sec", bus.load_seconds, 45);
    cyc(1, 6, 0, 1, 0, 0);
    check("add_drop_err", bus.key_err, 0);
    check("add_drop_min", bus.load_minutes, 1);
    check("add_drop_sec", bus.load_seconds, 15);
    key(7);
    rst = 1;
    key(3);
    check("rst_mid_sec", bus.load_seconds, 0);
    check("rst_mid_nd", bus.num_digits, 0);
    rst = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 24) == 0) run = ~run;
      rst = $urandom_range(0, 299) == 0;
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 11), $urandom_range(0, 29) == 0,
          $urandom_range(0, 7) == 0, run, $urandom_range(0, 79) == 0);
    end
    rst = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
